// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_if
// Brief    : Decoded-control bundle between the ID/branch logic and ctrl_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_pipe_if #(
  parameter int CTRL_W     = 8,
  parameter int REG_ADDR_W = 5
);

  // ID stage request
  logic                  id_valid;
  logic [CTRL_W-1:0]     id_ctrl;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  ex_branch_taken;

  // Pipeline control back to IF/ID and per-stage control to the datapath
  logic                  stall;
  logic                  flush;
  logic                  ex_valid;
  logic                  mem_valid;
  logic                  wb_valid;
  logic [CTRL_W-1:0]     ex_ctrl;
  logic [CTRL_W-1:0]     mem_ctrl;
  logic [CTRL_W-1:0]     wb_ctrl;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_reg_we;

  modport master (
    output id_valid, id_ctrl, id_rd, id_rs1, id_rs2, ex_branch_taken,
    input  stall, flush,
    input  ex_valid, mem_valid, wb_valid,
    input  ex_ctrl, mem_ctrl, wb_ctrl,
    input  ex_rd, mem_rd, wb_rd,
    input  wb_reg_we
  );

  modport slave (
    input  id_valid, id_ctrl, id_rd, id_rs1, id_rs2, ex_branch_taken,
    output stall, flush,
    output ex_valid, mem_valid, wb_valid,
    output ex_ctrl, mem_ctrl, wb_ctrl,
    output ex_rd, mem_rd, wb_rd,
    output wb_reg_we
  );

endinterface
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Brief    : ID/EX, EX/MEM, MEM/WB control pipeline with load-use stall and
//            taken-branch flush. Optional CTRL_PIPE_PERF_EN adds saturating
//            stall/flush cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
  parameter int CTRL_W     = 8,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  ctrl_pipe_if.slave     bus
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int c_bit_branch   = 7;
  localparam int c_bit_mem_read = 6;
  localparam int c_bit_reg_we   = 0;

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  logic                  ex_valid_q,  ex_valid_d;
  logic [CTRL_W-1:0]     ex_ctrl_q,   ex_ctrl_d;
  logic [REG_ADDR_W-1:0] ex_rd_q,     ex_rd_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [CTRL_W-1:0]     mem_ctrl_q,  mem_ctrl_d;
  logic [REG_ADDR_W-1:0] mem_rd_q,    mem_rd_d;
  logic                  wb_valid_q,  wb_valid_d;
  logic [CTRL_W-1:0]     wb_ctrl_q,   wb_ctrl_d;
  logic [REG_ADDR_W-1:0] wb_rd_q,     wb_rd_d;

  logic w_hazard;
  logic w_take;
  logic w_bubble;

  // --------------------------------------------------------------------------
  // Hazard and redirect detection
  // --------------------------------------------------------------------------
  // A load in EX cannot forward to the instruction in ID; one bubble lets the
  // load reach MEM, after which the ordinary forwarding paths apply.
  always_comb begin
    w_hazard = ex_valid_q
             & ex_ctrl_q[c_bit_mem_read]
             & (ex_rd_q != '0)
             & bus.id_valid
             & ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));
    w_take   = ex_valid_q & ex_ctrl_q[c_bit_branch] & bus.ex_branch_taken;
    w_bubble = w_take | w_hazard | ~bus.id_valid;
  end

  // --------------------------------------------------------------------------
  // Next-state for the pipeline registers
  // --------------------------------------------------------------------------
  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = '0;
    ex_rd_d    = '0;
    // Bubbles are fully zeroed so no memWrite/regWrite can leak downstream.
    if (!w_bubble) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = bus.id_ctrl;
      ex_rd_d    = bus.id_rd;
    end

    mem_valid_d = ex_valid_q;
    mem_ctrl_d  = ex_ctrl_q;
    mem_rd_d    = ex_rd_q;

    wb_valid_d  = mem_valid_q;
    wb_ctrl_d   = mem_ctrl_q;
    wb_rd_d     = mem_rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_rd_q     <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      mem_valid_q <= mem_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_rd_q    <= mem_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Flush wins over stall: the stalled ID instruction is being killed anyway.
  assign bus.flush     = w_take;
  assign bus.stall     = w_hazard & ~w_take;

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_ctrl   = ex_ctrl_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_ctrl  = mem_ctrl_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_ctrl   = wb_ctrl_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_reg_we = wb_valid_q & wb_ctrl_q[c_bit_reg_we] & (wb_rd_q != '0);

`ifdef CTRL_PIPE_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (bus.stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
    if (bus.flush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Brief    : Scoreboard bench for ctrl_pipe: directed scenarios then random
//            traffic against a stage-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

  logic clk;
  logic rst;

  ctrl_pipe_if #(.CTRL_W(8), .REG_ADDR_W(5)) bus ();

`ifdef CTRL_PIPE_PERF_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  ctrl_pipe #(.CTRL_W(8), .REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .stall_count (stall_count),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] c;
    logic [4:0] rd;
  } stage_t;

  typedef struct packed {
    stage_t      ex;
    stage_t      mem;
    stage_t      wb;
    logic        we;
    logic        stall;
    logic        flush;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: three stage slots, index 0 = EX, 1 = MEM, 2 = WB
  stage_t      m_st [3];
  logic [15:0] m_sc;
  logic [15:0] m_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end else begin
      n_pass++;
    end
  endtask

  // One cycle of stimulus: drive inputs, record what the DUT must show now,
  // then step the model across the coming clock edge.
  task automatic drive(input bit r, input bit v, input logic [7:0] c,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit tk);
    exp_t e;
    bit   hz;
    bit   take;
    @(negedge clk);
    rst                 = r;
    bus.id_valid        = v;
    bus.id_ctrl         = c;
    bus.id_rd           = rd;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    bus.ex_branch_taken = tk;

    hz   = m_st[0].v && m_st[0].c[6] && (m_st[0].rd != 0) && v &&
           ((m_st[0].rd == rs1) || (m_st[0].rd == rs2));
    take = m_st[0].v && m_st[0].c[7] && tk;

    e.ex    = m_st[0];
    e.mem   = m_st[1];
    e.wb    = m_st[2];
    e.we    = m_st[2].v && m_st[2].c[0] && (m_st[2].rd != 0);
    e.stall = hz && !take;
    e.flush = take;
    e.sc    = m_sc;
    e.fc    = m_fc;
    sb.push_back(e);

    if (r) begin
      for (int i = 0; i < 3; i++) m_st[i] = '0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      m_st[2] = m_st[1];
      m_st[1] = m_st[0];
      if (take || hz || !v) m_st[0] = '0;
      else                  m_st[0] = '{v: 1'b1, c: c, rd: rd};
      if (e.stall && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (e.flush && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 5'd0, 5'd0, 5'd0, 0);
  endtask

  // Monitor: samples mid-low-phase once inputs have settled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stall", {31'd0, bus.stall}, {31'd0, e.stall});
        check("flush", {31'd0, bus.flush}, {31'd0, e.flush});
        check("ex_stage",  {18'd0, bus.ex_valid,  bus.ex_ctrl,  bus.ex_rd},  {18'd0, e.ex});
        check("mem_stage", {18'd0, bus.mem_valid, bus.mem_ctrl, bus.mem_rd}, {18'd0, e.mem});
        check("wb_stage",  {18'd0, bus.wb_valid,  bus.wb_ctrl,  bus.wb_rd},  {18'd0, e.wb});
        check("wb_reg_we", {31'd0, bus.wb_reg_we}, {31'd0, e.we});
`ifdef CTRL_PIPE_PERF_EN
        check("stall_count", {16'd0, stall_count}, {16'd0, e.sc});
        check("flush_count", {16'd0, flush_count}, {16'd0, e.fc});
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) m_st[i] = '0;
    m_sc = 0;
    m_fc = 0;
    rst                 = 1'b1;
    bus.id_valid        = 1'b1;
    bus.id_ctrl         = 8'h83;
    bus.id_rd           = 5'd7;
    bus.id_rs1          = 5'd0;
    bus.id_rs2          = 5'd0;
    bus.ex_branch_taken = 1'b1;
    repeat (2) @(posedge clk);

    // Reset holds everything empty even with a live branch in ID
    drive(1, 1, 8'h83, 5'd7, 5'd0, 5'd0, 1);
    drive(1, 1, 8'h83, 5'd7, 5'd0, 5'd0, 1);

    // R-type flows EX -> MEM -> WB and writes back
    drive(0, 1, 8'b00010001, 5'd5, 5'd1, 5'd2, 0);
    idle(4);

    // Load-use: consumer held in ID for one stall cycle
    drive(0, 1, 8'b01100011, 5'd3, 5'd1, 5'd2, 0);
    drive(0, 1, 8'b00010001, 5'd6, 5'd3, 5'd4, 0);
    drive(0, 1, 8'b00010001, 5'd6, 5'd3, 5'd4, 0);
    idle(4);

    // Load to x0 never stalls; regWrite to x0 does not write back
    drive(0, 1, 8'b01100011, 5'd0, 5'd1, 5'd2, 0);
    drive(0, 1, 8'b00010001, 5'd0, 5'd0, 5'd0, 0);
    idle(4);

    // Taken branch with a simultaneous hazard: flush wins
    drive(0, 1, 8'hC0, 5'd4, 5'd1, 5'd2, 0);
    drive(0, 1, 8'b00010001, 5'd9, 5'd4, 5'd0, 1);
    // taken ignored when EX is not a branch: stall remains
    drive(0, 1, 8'h40, 5'd4, 5'd1, 5'd2, 0);
    drive(0, 1, 8'b00010001, 5'd9, 5'd4, 5'd0, 1);
    idle(4);

    // Counter scenario: fresh reset, 3 stalls then 2 flushes, then reset
    drive(1, 0, 8'h00, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'h40, 5'd8, 5'd0, 5'd0, 0);
      drive(0, 1, 8'h11, 5'd1, 5'd8, 5'd0, 0);
      idle(1);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 8'h80, 5'd0, 5'd0, 5'd0, 0);
      drive(0, 1, 8'h11, 5'd1, 5'd0, 5'd0, 1);
    end
    idle(2);
    drive(1, 0, 8'h00, 5'd0, 5'd0, 5'd0, 0);
    idle(2);

    // Random traffic with narrow register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            8'($urandom),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1);
    end
    idle(4);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: actual=%0d pending required=0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
